// File: rtl/snn_step_scheduler.sv
// Steps through T neuron blocks for each time step of a run and emits one AXI4-stream beat per captured spike vector.
// Build with SNN_SCHED_PERF_EN defined to add the stall_cycles counter port.
module snn_step_scheduler #(
    parameter int unsigned N  = 32,
    parameter int unsigned T  = 1,
    parameter int unsigned TA = (T > 1) ? $clog2(T) : 1,
    parameter int unsigned TS = 33,
    parameter int unsigned NN = (N + 7) / 8,
    parameter int unsigned NU = $clog2(TS + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic [NU-1:0]      num_steps,
    output logic               busy,
    output logic               done,
    output logic               blk_start,
    output logic [TA-1:0]      blk_sel,
    output logic [NU-1:0]      blk_step,
    input  logic               blk_done,
    input  logic [N-1:0]       blk_spikes,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic [NN*8-1:0]    m_axis_tdata,
    output logic [NU-1:0]      m_axis_tuser,
    output logic               m_axis_tlast
`ifdef SNN_SCHED_PERF_EN
    ,
    output logic [31:0]        stall_cycles
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        SEND,
        FIN
    } state_t;

    localparam logic [TA-1:0] BLK_LAST = TA'(T - 1);
    localparam logic [NU-1:0] STEP_MAX = NU'(TS);

    state_t            state_q, state_d;
    logic [NU-1:0]     step_q, step_d;
    logic [TA-1:0]     blk_q, blk_d;
    logic [NU-1:0]     cnt_q, cnt_d;
    logic [NN*8-1:0]   dat_q, dat_d;
    logic              last_beat;

    // cnt_q is never zero outside IDLE/FIN, so cnt_q-1 cannot underflow where it matters.
    assign last_beat = (step_q == (cnt_q - NU'(1))) && (blk_q == BLK_LAST);

    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        blk_d         = blk_q;
        cnt_d         = cnt_q;
        dat_d         = dat_q;
        busy          = 1'b0;
        done          = 1'b0;
        blk_start     = 1'b0;
        m_axis_tvalid = 1'b0;
        case (state_q)
            IDLE: begin
                if (run) begin
                    if (num_steps == '0) begin
                        state_d = FIN;
                    end else begin
                        state_d = ISSUE;
                        cnt_d   = (num_steps > STEP_MAX) ? STEP_MAX : num_steps;
                        step_d  = '0;
                        blk_d   = '0;
                    end
                end
            end
            ISSUE: begin
                busy      = 1'b1;
                blk_start = 1'b1;
                state_d   = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (blk_done) begin
                    dat_d          = '0;
                    dat_d[N-1:0]   = blk_spikes;
                    state_d        = SEND;
                end
            end
            SEND: begin
                busy          = 1'b1;
                m_axis_tvalid = 1'b1;
                if (m_axis_tready) begin
                    if (last_beat) begin
                        // Park counters at zero so they never pass count-1 / T-1.
                        state_d = FIN;
                        step_d  = '0;
                        blk_d   = '0;
                    end else begin
                        state_d = ISSUE;
                        if (blk_q == BLK_LAST) begin
                            blk_d  = '0;
                            step_d = step_q + NU'(1);
                        end else begin
                            blk_d  = blk_q + TA'(1);
                        end
                    end
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            step_q  <= '0;
            blk_q   <= '0;
            cnt_q   <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            blk_q   <= blk_d;
            cnt_q   <= cnt_d;
            dat_q   <= dat_d;
        end
    end

    assign blk_sel      = blk_q;
    assign blk_step     = step_q;
    assign m_axis_tdata = dat_q;
    assign m_axis_tuser = step_q;
    assign m_axis_tlast = (state_q == SEND) && last_beat;

`ifdef SNN_SCHED_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if ((state_q == IDLE) && run) begin
            stall_q <= '0;
        end else if (m_axis_tvalid && !m_axis_tready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_snn_step_scheduler.sv
// Scoreboard bench for snn_step_scheduler (T=4, N=28 so tdata zero-extension is visible).
`timescale 1ns/1ps
module tb_snn_step_scheduler;
    localparam int BN  = 28;
    localparam int BT  = 4;
    localparam int BTS = 33;
    localparam int BTA = 2;
    localparam int BNU = 6;
    localparam int BW  = 32;

    typedef struct { int step; int blk; bit last; } issue_t;
    typedef struct { logic [BW-1:0] data; int user; bit last; } beat_t;

    logic             clk;
    logic             reset;
    logic             run;
    logic [BNU-1:0]   num_steps;
    logic             busy, done, blk_start;
    logic [BTA-1:0]   blk_sel;
    logic [BNU-1:0]   blk_step;
    logic             blk_done;
    logic [BN-1:0]    blk_spikes;
    logic             m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [BW-1:0]    m_axis_tdata;
    logic [BNU-1:0]   m_axis_tuser;
`ifdef SNN_SCHED_PERF_EN
    logic [31:0]      stall_cycles;
`endif

    snn_step_scheduler #(.N(BN), .T(BT)) dut (
        .clk(clk), .reset(reset), .run(run), .num_steps(num_steps),
        .busy(busy), .done(done), .blk_start(blk_start), .blk_sel(blk_sel),
        .blk_step(blk_step), .blk_done(blk_done), .blk_spikes(blk_spikes),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
        .m_axis_tlast(m_axis_tlast)
`ifdef SNN_SCHED_PERF_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    int     errors;
    int     checks;
    int     beats;
    int     last_user;
    int     stall_model;
    int     stall_left;
    bit     rand_mode;
    issue_t exp_issue[$];
    beat_t  exp_beat[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: got %s (t=%0t)", name, what, $time);
    endtask

    // Block model: answers each blk_start after a latency, sometimes adds a stray blk_done.
    initial begin : responder
        bit     pend;
        bit     spur;
        int     wait_cnt;
        issue_t cur;
        beat_t  b;
        pend = 0; spur = 0; wait_cnt = 0;
        blk_done = 1'b0;
        blk_spikes = '0;
        forever begin
            @(negedge clk);
            blk_done = 1'b0;
            if (reset) begin
                pend = 0;
                spur = 0;
                continue;
            end
            if (pend && wait_cnt == 0) begin
                blk_done   = 1'b1;
                blk_spikes = BN'($urandom);
                b.data = BW'(blk_spikes);
                b.user = cur.step;
                b.last = cur.last;
                exp_beat.push_back(b);
                pend = 0;
                spur = rand_mode && ($urandom_range(0, 2) == 0);
            end else if (pend) begin
                wait_cnt--;
            end else if (spur) begin
                blk_done   = 1'b1;
                blk_spikes = BN'($urandom);
                spur = 0;
            end
            if (blk_start) begin
                if (exp_issue.size() == 0) begin
                    fail("unexpected_blk_start", "blk_start with no step pending");
                end else begin
                    cur = exp_issue.pop_front();
                    check("blk_sel", blk_sel, cur.blk);
                    check("blk_step", blk_step, cur.step);
                    pend = 1;
                    wait_cnt = rand_mode ? $urandom_range(0, 3) : 0;
                end
            end
        end
    end

    initial begin : ready_drv
        m_axis_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) m_axis_tready = 1'b0;
            else if (m_axis_tvalid && stall_left > 0) begin
                m_axis_tready = 1'b0;
                stall_left--;
            end else if (rand_mode) m_axis_tready = ($urandom_range(0, 1) == 1);
            else m_axis_tready = 1'b1;
        end
    end

    initial begin : monitor
        bit              held;
        logic [BW-1:0]   hd;
        logic [BNU-1:0]  hu;
        logic            hl;
        beat_t           e;
        held = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                held = 0;
                continue;
            end
            if (m_axis_tvalid) begin
                if (held) begin
                    check("hold_tdata", m_axis_tdata, hd);
                    check("hold_tuser", m_axis_tuser, hu);
                    check("hold_tlast", m_axis_tlast, hl);
                end
                check("start_in_send", blk_start, 1'b0);
                if (exp_beat.size() == 0) begin
                    fail("unexpected_beat", "tvalid with no beat pending");
                end else begin
                    e = exp_beat[0];
                    check("tdata", m_axis_tdata, e.data);
                    check("tuser", m_axis_tuser, e.user);
                    check("tlast", m_axis_tlast, e.last);
                end
                if (m_axis_tready) begin
                    if (exp_beat.size() != 0) void'(exp_beat.pop_front());
                    beats++;
                    last_user = int'(m_axis_tuser);
                    held = 0;
                end else begin
                    held = 1;
                    hd = m_axis_tdata;
                    hu = m_axis_tuser;
                    hl = m_axis_tlast;
                    stall_model++;
                end
            end else begin
                if (held) fail("tvalid_dropped", "tvalid=0 before handshake");
                held = 0;
            end
        end
    end

    // Expected issue order: every block for step 0, then step 1, ... up to the clamped count.
    task automatic start_run(input int n);
        int     s;
        issue_t it;
        s = (n > BTS) ? BTS : n;
        for (int st = 0; st < s; st++) begin
            for (int bk = 0; bk < BT; bk++) begin
                it.step = st;
                it.blk  = bk;
                it.last = (st == s - 1) && (bk == BT - 1);
                exp_issue.push_back(it);
            end
        end
        @(negedge clk);
        run = 1'b1;
        num_steps = BNU'(n);
        stall_model = 0;
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic do_run(input int n, input int exp_cyc, input int poke_at);
        int cyc;
        start_run(n);
        if (n != 0) begin
            check("busy_after_run", busy, 1'b1);
        end else begin
            check("busy_zero_run", busy, 1'b0);
            check("start_zero_run", blk_start, 1'b0);
        end
        cyc = 1;
        while (!done && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            run = (cyc == poke_at);
            if (run) num_steps = BNU'(7);
        end
        run = 1'b0;
        check("done_seen", done, 1'b1);
        if (exp_cyc > 0) check("run_to_done", cyc, exp_cyc);
        check("busy_at_done", busy, 1'b0);
        check("beats_drained", exp_beat.size(), 0);
        check("issues_drained", exp_issue.size(), 0);
`ifdef SNN_SCHED_PERF_EN
        check("stall_cycles", stall_cycles, stall_model);
`endif
        @(negedge clk);
        check("done_pulse", done, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_blk_start"}, blk_start, 1'b0);
        check({tag, "_blk_sel"}, blk_sel, '0);
        check({tag, "_blk_step"}, blk_step, '0);
        check({tag, "_tvalid"}, m_axis_tvalid, 1'b0);
        check({tag, "_tdata"}, m_axis_tdata, '0);
        check({tag, "_tuser"}, m_axis_tuser, '0);
        check({tag, "_tlast"}, m_axis_tlast, 1'b0);
`ifdef SNN_SCHED_PERF_EN
        check({tag, "_stall"}, stall_cycles, '0);
`endif
    endtask

    initial begin : main
        int k;
        errors = 0; checks = 0; beats = 0; last_user = -1;
        stall_model = 0; stall_left = 0; rand_mode = 0;
        reset = 1'b1; run = 1'b0; num_steps = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        do_run(3, 3 * 3 * BT + 1, 0);
        do_run(2, 3 * 2 * BT + 1, 0);

        stall_left = 5;
        do_run(1, 3 * BT + 1 + 5, 0);
`ifdef SNN_SCHED_PERF_EN
        check("stall_five", stall_cycles, 5);
`endif

        do_run(0, 1, 0);

        rand_mode = 1;
        beats = 0;
        do_run(40, 0, 0);
        check("clamp_beats", beats, BTS * BT);
        check("clamp_last_tuser", last_user, BTS - 1);

        for (int i = 0; i < 6; i++) begin
            do_run($urandom_range(1, 5), 0, $urandom_range(3, 20));
        end
        rand_mode = 0;

        // Reset while beat 7 of a two-step run is stalled.
        start_run(2);
        k = 0;
        while (!(blk_start && blk_sel == 2'd2 && blk_step == 6'd1) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("reach_beat7", k < 200, 1'b1);
        stall_left = 1000;
        k = 0;
        while (!m_axis_tvalid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("beat7_valid", m_axis_tvalid, 1'b1);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1 check_all_zero("midrun_reset");
        exp_issue.delete();
        exp_beat.delete();
        stall_left = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        do_run(1, 3 * BT + 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/snn_step_scheduler.md
# snn_step_scheduler

Sequences the SNN neuron blocks over a run of time steps. For each step it kicks each of the T neuron blocks in turn with a start/done handshake and captures that block's N-bit spike vector. It then streams the vector out as one AXI4-stream beat, with the time-step index on tuser. It sits between the host run command and the neuron-block array, feeding the spike output stream.

## Interface

Parameters:
- N, 32, neurons per block (spike vector width)
- T, 1, number of neuron blocks
- TA, max($clog2(T),1), block-select width
- TS, 33, maximum number of time steps
- NN, ceil(N/8), tdata width in bytes
- NU, $clog2(TS+1), tuser / step-count width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- run  in  1  start pulse; sampled only in IDLE
- num_steps  in  NU  steps to run, sampled with run; values > TS clamp to TS
- busy  out  1  high from the cycle after run is accepted until done
- done  out  1  one-cycle pulse at end of run
- blk_start  out  1  one-cycle pulse: selected block computes one step
- blk_sel  out  TA  block index, valid while blk_start and until blk_done
- blk_step  out  NU  current step index (0-based), valid with blk_sel
- blk_done  in  1  selected block finished; blk_spikes valid this cycle
- blk_spikes  in  N  spike vector of selected block
- m_axis_tvalid  out  1  spike beat valid
- m_axis_tready  in  1  downstream ready
- m_axis_tdata  out  NN*8  spike vector, zero-extended in the MSBs
- m_axis_tuser  out  NU  step index of the beat
- m_axis_tlast  out  1  last beat of the run (last block, last step)

## Operation

- FSM states: IDLE, ISSUE, WAIT, SEND, FIN.
- IDLE:
  - run=1 with num_steps≠0 → ISSUE; latch the clamped step count; step=0, blk=0.
  - run=1 with num_steps=0 → FIN; no block activity and no beats.
- ISSUE: blk_start=1 for exactly one cycle → WAIT.
- WAIT:
  - Hold blk_sel and blk_step.
  - On blk_done, register blk_spikes into the output data register → SEND.
  - blk_done in any other state is ignored.
- SEND:
  - m_axis_tvalid=1; tdata, tuser and tlast are stable until the handshake.
  - On tvalid&tready, the block index advances. If blk=T-1, blk wraps to 0 and step increments. If step=count-1 and blk=T-1, the next state is FIN; otherwise ISSUE.
- FIN: done=1 for one cycle; busy=0 from this cycle → IDLE.
- run while not in IDLE is ignored; a new run is not queued.
- Counters: step is NU bits and blk is TA bits. Neither counter exceeds its bound, so no wrap beyond count-1 and T-1.
- Reset, asynchronous and at any time including mid-handshake:
  - State → IDLE.
  - Outputs → 0: busy, done, blk_start, blk_sel, blk_step, m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast.
  - Any pending beat is dropped.

## Timing

- run accepted at cycle c → busy=1 and blk_start=1 at c+1.
- blk_done at cycle k → m_axis_tvalid=1 at k+1.
- Handshake at cycle h:
  - Not the last beat: next blk_start at h+1.
  - Last beat: done=1 at h+1.
- Minimum per beat: 3 cycles (ISSUE, WAIT with blk_done in the same cycle as entry, SEND with tready=1).
- Run of S steps with zero-latency blocks and tready held high: exactly 3·S·T + 1 cycles from run to done.
- num_steps=0: done at c+1; busy stays 0.

## Configuration

- SNN_SCHED_PERF_EN defined:
  - Adds output stall_cycles (32 bits).
  - Counts cycles with m_axis_tvalid=1 and m_axis_tready=0.
  - Cleared when run is accepted; saturates at 2^32-1; reset value 0.
  - Holds its value after done.
- SNN_SCHED_PERF_EN undefined: the port and counter are absent; all other behaviour is identical.

## Test plan

- Default params, num_steps=3, blk_done one cycle after each blk_start, tready=1:
  - 3 beats with tuser 0, 1, 2 and tlast only on the third beat.
  - tdata = blk_spikes zero-extended to 32 bits.
  - done 10 cycles after run.
- T=4, num_steps=2:
  - blk_sel sequence 0,1,2,3,0,1,2,3 and blk_step 0,0,0,0,1,1,1,1.
  - 8 beats, tlast on beat 8.
- tready low for 5 cycles on beat 1:
  - tvalid, tdata and tuser held stable for those cycles.
  - No blk_start until after the handshake.
  - With SNN_SCHED_PERF_EN: stall_cycles=5.
- Edge cases on num_steps:
  - num_steps=0 → done at c+1, no blk_start, no beats.
  - num_steps=40 → clamped to 33; exactly 33 beats, last tuser=32.
- Edge cases on run and blk_done:
  - run pulsed while busy → ignored; beat count unchanged.
  - Spurious blk_done in SEND → no extra beat.
- Reset asserted during SEND with tready=0 → all outputs 0 immediately. A new run then restarts from step 0, block 0.
